// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM bus bundle between the bus_controller master and the memory responder.
interface avalon_mem_responder_if;
   logic [31:0] av_address;
   logic        av_read;
   logic        av_write;
   logic [31:0] av_writedata;
   logic [3:0]  av_byteenable;
   logic        av_waitrequest;
   logic [31:0] av_readdata;

   modport master (
      output av_address, av_read, av_write, av_writedata, av_byteenable,
      input  av_waitrequest, av_readdata
   );

   modport slave (
      input  av_address, av_read, av_write, av_writedata, av_byteenable,
      output av_waitrequest, av_readdata
   );
endinterface

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave memory model: every transfer is stretched by WAIT_CYCLES of waitrequest,
// and protocol violations are latched into sticky error flags.
module avalon_mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter string       INIT_FILE   = ""
) (
   input  logic                    clk,
   input  logic                    reset,
   avalon_mem_responder_if.slave   av,
   output logic [3:0]              err_flags
);

   localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
   localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("avalon_mem_responder: WAIT_CYCLES must be within 1..15");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wait_q, wait_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  err_q, err_d;

   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic        is_wr_q;

   logic [31:0] mem_q [DEPTH];

   logic                  latch, commit, abort;
   logic [31:0]           addr_e, wdata_e, offset_e;
   logic [3:0]            be_e;
   logic                  is_wr_e, in_range_e;
   logic [DEPTH_LOG2-1:0] idx_e;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch   = 1'b0;
      commit  = 1'b0;
      abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (av.av_read || av.av_write) begin
               latch = 1'b1;
               cnt_d = CNT_LOAD;
               if (WAIT_CYCLES == 1) begin
                  state_d = S_ACCEPT;
                  commit  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!av.av_read && !av.av_write) begin
               state_d = S_IDLE;
               abort   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = S_ACCEPT;
                  commit  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // With a single wait cycle the commit coincides with the latch edge, so the
   // request is taken straight from the bus instead of the latched copy.
   always_comb begin
      addr_e     = latch ? av.av_address : addr_q;
      wdata_e    = latch ? av.av_writedata : wdata_q;
      be_e       = latch ? av.av_byteenable : be_q;
      is_wr_e    = latch ? (av.av_write && !av.av_read) : is_wr_q;
      offset_e   = addr_e - BASE_ADDR;
      in_range_e = (addr_e >= BASE_ADDR) && ({1'b0, offset_e} < SPAN);
      idx_e      = offset_e[DEPTH_LOG2+1:2];

      rdata_d = rdata_q;
      if (commit && !is_wr_e) begin
         rdata_d = in_range_e ? mem_q[idx_e] : 32'h0000_0000;
      end

      err_d = err_q;
      if (latch) begin
         if (av.av_read && av.av_write)  err_d[0] = 1'b1;
         if (!in_range_e)                err_d[1] = 1'b1;
         if (av.av_address[1:0] != 2'b0) err_d[2] = 1'b1;
      end
      if (abort) err_d[3] = 1'b1;

      wait_d = (state_d != S_ACCEPT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wait_q  <= 1'b1;
         rdata_q <= 32'h0000_0000;
         err_q   <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (latch) begin
         addr_q  <= av.av_address;
         wdata_q <= av.av_writedata;
         be_q    <= av.av_byteenable;
         is_wr_q <= av.av_write && !av.av_read;
      end
   end

   // Memory survives reset, but a reset edge must still suppress a pending commit.
   always_ff @(posedge clk) begin
      if (!reset && commit && is_wr_e && in_range_e) begin
         for (int i = 0; i < 4; i++) begin
            if (be_e[i]) mem_q[idx_e][8*i +: 8] <= wdata_e[8*i +: 8];
         end
      end
   end

   assign av.av_waitrequest = wait_q;
   assign av.av_readdata    = rdata_q;
   assign err_flags         = err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Randomized bench for avalon_mem_responder: three instances (1, 2 and 3 wait cycles)
// checked against a transaction-level memory/flag model.
module tb_avalon_mem_responder;

   localparam int          DL2   = 6;
   localparam int          WORDS = 1 << DL2;
   localparam logic [31:0] BASE  = 32'h0000_0100;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        rd    [3];
   logic        wr    [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [3:0]  be    [3];
   wire         wreq  [3];
   wire  [31:0] rdata [3];
   wire  [3:0]  errs  [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      avalon_mem_responder_if bus();
      assign bus.av_read       = rd[g];
      assign bus.av_write      = wr[g];
      assign bus.av_address    = addr[g];
      assign bus.av_writedata  = wdata[g];
      assign bus.av_byteenable = be[g];
      assign wreq[g]           = bus.av_waitrequest;
      assign rdata[g]          = bus.av_readdata;

      avalon_mem_responder #(
         .DEPTH_LOG2  (DL2),
         .BASE_ADDR   (BASE),
         .WAIT_CYCLES (g + 1)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .av        (bus),
         .err_flags (errs[g])
      );
   end

   logic [31:0] mem_m   [3][WORDS];
   logic [31:0] rdata_m [3];
   logic [3:0]  err_m   [3];
   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < 4 * WORDS);
   endfunction

   // Effect of one completed transfer on the reference state.
   task automatic model_apply(input int g, input bit r, input bit w,
                              input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      int idx;
      idx = int'((a - BASE) / 4) % WORDS;
      if (r && w)        err_m[g][0] = 1'b1;
      if (!in_rng(a))    err_m[g][1] = 1'b1;
      if (a[1:0] != 2'b0) err_m[g][2] = 1'b1;
      if (r) begin
         rdata_m[g] = in_rng(a) ? mem_m[g][idx] : 32'h0;
      end else if (in_rng(a)) begin
         for (int i = 0; i < 4; i++) if (b[i]) mem_m[g][idx][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   task automatic check_reset_state();
      for (int g = 0; g < 3; g++) begin
         check_eq("rst_wreq", 32'(wreq[g]), 32'h1);
         check_eq("rst_rdata", rdata[g], 32'h0);
         check_eq("rst_err", 32'(errs[g]), 32'h0);
      end
   endtask

   // One full master transfer; bus fields are scrambled after the latch edge.
   task automatic xfer(input int g, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      int n;
      @(posedge clk); #1;
      rd[g] = r; wr[g] = w; addr[g] = a; wdata[g] = d; be[g] = b;
      @(negedge clk);
      n = 0;
      while (wreq[g] === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
         if (wreq[g] === 1'b1) begin
            addr[g] = $urandom; wdata[g] = $urandom; be[g] = 4'($urandom);
         end
      end
      check_eq("wait_len", 32'(n), 32'(g + 1));
      model_apply(g, r, w, a, d, b);
      check_eq("rdata", rdata[g], rdata_m[g]);
      check_eq("err", 32'(errs[g]), 32'(err_m[g]));
      @(posedge clk); #1;
      rd[g] = 1'b0; wr[g] = 1'b0;
      @(negedge clk);
      check_eq("idle_wreq", 32'(wreq[g]), 32'h1);
   endtask

   function automatic logic [31:0] rand_addr();
      int k;
      k = $urandom_range(0, 11);
      if (k <= 7)       return BASE + 4 * $urandom_range(0, WORDS - 1);
      else if (k == 8)  return BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3);
      else if (k == 9)  return BASE + 4 * WORDS + 4 * $urandom_range(0, 15);
      else if (k == 10) return BASE - 4 * $urandom_range(1, 8);
      else              return BASE + 4 * (WORDS - 1);
   endfunction

   initial begin
      logic [31:0] a, old;
      int k;
      for (int g = 0; g < 3; g++) begin
         rd[g] = 1'b0; wr[g] = 1'b0; addr[g] = '0; wdata[g] = '0; be[g] = '0;
         rdata_m[g] = '0; err_m[g] = '0;
      end

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_state();

      for (int g = 0; g < 3; g++)
         for (int i = 0; i < WORDS; i++)
            xfer(g, 1'b0, 1'b1, BASE + 4 * i, $urandom, 4'hF);

      xfer(1, 1'b0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
      xfer(1, 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
      check_eq("deadbeef", rdata[1], 32'hDEADBEEF);

      xfer(1, 1'b0, 1'b1, BASE + 32'h20, 32'h11223344, 4'hF);
      xfer(1, 1'b0, 1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101);
      xfer(1, 1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'hF);
      check_eq("byte_lanes", rdata[1], 32'h11BB33DD);
      xfer(1, 1'b0, 1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'b0000);
      xfer(1, 1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
      check_eq("be_zero", rdata[1], 32'h11BB33DD);

      xfer(1, 1'b1, 1'b0, BASE + 4 * WORDS, 32'h0, 4'hF);
      check_eq("oor_rdata", rdata[1], 32'h0);
      check_eq("oor_flag", 32'(errs[1][1]), 32'h1);

      a = BASE + 4 * 5;
      @(posedge clk); #1;
      rd[2] = 1'b1; addr[2] = a;
      @(negedge clk);
      check_eq("abort_first", 32'(wreq[2]), 32'h1);
      @(posedge clk); #1;
      rd[2] = 1'b0;
      err_m[2][3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("abort_wreq", 32'(wreq[2]), 32'h1);
      end
      check_eq("abort_err", 32'(errs[2]), 32'(err_m[2]));
      xfer(2, 1'b1, 1'b0, a, 32'h0, 4'hF);

      @(posedge clk); #1;
      rd[0] = 1'b1; addr[0] = BASE + 4 * 3;
      for (int i = 0; i < 3; i++) begin
         a = addr[0];
         @(negedge clk);
         check_eq("b2b_high", 32'(wreq[0]), 32'h1);
         model_apply(0, 1'b1, 1'b0, a, 32'h0, 4'h0);
         @(negedge clk);
         check_eq("b2b_low", 32'(wreq[0]), 32'h0);
         check_eq("b2b_rdata", rdata[0], rdata_m[0]);
         @(posedge clk); #1;
         if (i < 2) addr[0] = BASE + 4 * (7 + 9 * i);
         else rd[0] = 1'b0;
      end

      for (int t = 0; t < 90; t++) begin
         int g;
         g = $urandom_range(0, 2);
         k = $urandom_range(0, 3);
         xfer(g, (k == 0 || k >= 2), (k == 1 || k == 2), rand_addr(), $urandom, 4'($urandom));
      end

      old = mem_m[1][0];
      @(posedge clk); #1;
      wr[1] = 1'b1; addr[1] = BASE; wdata[1] = 32'hCAFEF00D; be[1] = 4'hF;
      @(negedge clk);
      check_eq("midrst_wreq", 32'(wreq[1]), 32'h1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; wr[1] = 1'b0;
      for (int g = 0; g < 3; g++) begin
         rdata_m[g] = '0; err_m[g] = '0;
      end
      @(negedge clk);
      check_reset_state();
      xfer(1, 1'b1, 1'b0, BASE, 32'h0, 4'hF);
      check_eq("midrst_keep", rdata[1], old);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
